// File: rtl/circle_pkg.sv
// circle_pkg: shared FSM state, octant index type and default screen size for circle_engine
package circle_pkg;
  typedef enum logic [1:0] {IDLE, PLOT, STEP, DONE} state_t;
  typedef logic [2:0] oct_t;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
endpackage

// File: rtl/circle_octant_point.sv
// circle_octant_point: maps centre plus offsets to the point of one octant and flags whether it lies on screen
module circle_octant_point
  import circle_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic [X_W-1:0]        cx,
  input  logic [Y_W-1:0]        cy,
  input  logic signed [X_W+1:0] ox,
  input  logic signed [X_W+1:0] oy,
  input  oct_t                  oct,
  output logic signed [X_W+1:0] px,
  output logic signed [X_W+1:0] py,
  output logic                  on_screen
);
  localparam int W = X_W + 2;
  logic signed [W-1:0] scx, scy;
  assign scx = W'(cx);
  assign scy = W'(cy);
  assign px = oct inside {3'd0, 3'd7} ? scx + ox :
              oct inside {3'd1, 3'd6} ? scx + oy :
              oct inside {3'd2, 3'd5} ? scx - oy : scx - ox;
  assign py = oct inside {3'd0, 3'd3} ? scy + oy :
              oct inside {3'd1, 3'd2} ? scy + ox :
              oct inside {3'd4, 3'd7} ? scy - oy : scy - ox;
  assign on_screen = !px[W-1] && px < W'(SCREEN_W) && !py[W-1] && py < W'(SCREEN_H);
endmodule

// File: rtl/circle_engine.sv
// circle_engine: midpoint circle rasteriser emitting one octant candidate per clock; CIRCLE_CLIP_EN enables screen clipping
module circle_engine
  import circle_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [X_W-1:0] centre_x,
  input  logic [Y_W-1:0] centre_y,
  input  logic [X_W-1:0] radius,
  input  logic [2:0]     colour,
  input  logic [7:0]     octant_mask,
  output logic           done,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot
);
  localparam int W = X_W + 2;
`ifdef CIRCLE_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif
  state_t state, state_n;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic [2:0] col;
  logic [7:0] mask;
  oct_t oct;
  logic signed [W-1:0] ox, oy, crit, nx, ny, crit_n, px, py;
  logic le0, on_screen;
  assign le0 = crit[W-1] || crit == '0;
  assign ny = oy + W'(1);
  assign nx = le0 ? ox : ox - W'(1);
  assign crit_n = le0 ? crit + (ny <<< 1) + W'(1) : crit + ((ny - nx) <<< 1) + W'(1);
  circle_octant_point #(.X_W(X_W), .Y_W(Y_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_pt (
    .cx(cx), .cy(cy), .ox(ox), .oy(oy), .oct(oct), .px(px), .py(py), .on_screen(on_screen)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? PLOT : IDLE;
      PLOT: state_n = oct == 3'd7 ? STEP : PLOT;
      STEP: state_n = ny <= nx ? PLOT : DONE;
      DONE: state_n = start ? DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cx    <= '0;
      cy    <= '0;
      col   <= '0;
      mask  <= '0;
      oct   <= '0;
      ox    <= '0;
      oy    <= '0;
      crit  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        cx   <= centre_x;
        cy   <= centre_y;
        col  <= colour;
        mask <= octant_mask;
        oct  <= '0;
        ox   <= W'(radius);
        oy   <= '0;
        crit <= W'(1) - W'(radius);
      end
      if (state == PLOT) oct <= oct + 3'd1;
      if (state == STEP) begin
        ox   <= nx;
        oy   <= ny;
        crit <= crit_n;
      end
    end
  end
  assign done       = state == DONE;
  assign vga_plot   = state == PLOT && mask[oct] && (on_screen || !CLIP);
  assign vga_x      = X_W'(px);
  assign vga_y      = Y_W'(py);
  assign vga_colour = col;
endmodule

// File: tb/tb_circle_engine.sv
// tb_circle_engine: directed checks of circle_engine timing, plotted pixel sets, masking, clipping and handshake
module tb_circle_engine;
  logic clk = 1'b0;
  logic rst, start, done, vga_plot;
  logic [7:0] centre_x, radius, octant_mask, vga_x;
  logic [6:0] centre_y, vga_y;
  logic [2:0] colour, vga_colour;
  int tests = 0;
  int fails = 0;
  int xs[$];
  int ys[$];
  int edges, cols_bad, cnt;
  always #5 clk = ~clk;
  circle_engine dut (
    .clk(clk), .rst(rst), .start(start), .centre_x(centre_x), .centre_y(centre_y),
    .radius(radius), .colour(colour), .octant_mask(octant_mask), .done(done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );
  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int has(input int x, input int y);
    foreach (xs[i]) if (xs[i] == x && ys[i] == y) return 1;
    return 0;
  endfunction
  task automatic draw(input int cx, input int cy, input int r, input int col, input int mask, input bit drop);
    start = 1'b0;
    @(negedge clk);
    centre_x = 8'(cx);
    centre_y = 7'(cy);
    radius = 8'(r);
    colour = 3'(col);
    octant_mask = 8'(mask);
    start = 1'b1;
    @(posedge clk);
    #1;
    centre_x = ~centre_x;
    centre_y = ~centre_y;
    radius = ~radius;
    colour = ~colour;
    octant_mask = ~octant_mask;
    if (drop) start = 1'b0;
    xs.delete();
    ys.delete();
    edges = 0;
    cols_bad = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (i == 0) check("done_low_after_start", int'(done), 0);
      if (done) break;
      if (vga_plot) begin
        xs.push_back(int'(vga_x));
        ys.push_back(int'(vga_y));
        if (int'(vga_colour) != (col & 7)) cols_bad++;
      end
      @(posedge clk);
      edges++;
    end
    check("done_seen", int'(done), 1);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    centre_x = '0;
    centre_y = '0;
    radius = '0;
    colour = '0;
    octant_mask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_done", int'(done), 0);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_x", int'(vga_x), 0);
    check("rst_y", int'(vga_y), 0);
    check("rst_colour", int'(vga_colour), 0);
    rst = 1'b0;
    centre_x = 8'd80;
    centre_y = 7'd60;
    radius = 8'd40;
    colour = 3'd6;
    octant_mask = 8'hFF;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("middraw_plot", int'(vga_plot), 1);
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_plot", int'(vga_plot), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_colour", int'(vga_colour), 0);
    rst = 1'b0;
    draw(80, 60, 0, 5, 'hFF, 1'b1);
    check("r0_edges", edges, 9);
    check("r0_plots", xs.size(), 8);
    cnt = 0;
    foreach (xs[i]) if (xs[i] != 80 || ys[i] != 60) cnt++;
    check("r0_offcentre", cnt, 0);
    check("r0_colour", cols_bad, 0);
    draw(80, 60, 1, 3, 'hFF, 1'b1);
    check("r1_edges", edges, 18);
    check("r1_plots", xs.size(), 16);
    check("r1_has_81_61", has(81, 61), 1);
    check("r1_has_80_59", has(80, 59), 1);
    draw(80, 60, 2, 2, 'hFF, 1'b0);
    check("r2_edges", edges, 18);
    check("r2_plots", xs.size(), 16);
    check("r2_has_82_60", has(82, 60), 1);
    check("r2_has_80_62", has(80, 62), 1);
    check("r2_has_78_60", has(78, 60), 1);
    check("r2_has_80_58", has(80, 58), 1);
    check("r2_has_81_62", has(81, 62), 1);
    check("r2_has_79_58", has(79, 58), 1);
    cnt = 0;
    foreach (xs[i]) if (xs[i] < 78 || xs[i] > 82 || ys[i] < 58 || ys[i] > 62) cnt++;
    check("r2_far", cnt, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vga_plot || !done) cnt++;
    end
    check("hold_done_noplot", cnt, 0);
    draw(80, 60, 40, 7, 'h01, 1'b1);
    check("m01_first_x", xs.size() > 0 ? xs[0] : -1, 120);
    check("m01_first_y", ys.size() > 0 ? ys[0] : -1, 60);
    cnt = 0;
    foreach (xs[i]) if (xs[i] < 80 || ys[i] < 60 || xs[i] - 80 < ys[i] - 60) cnt++;
    check("m01_octant0_only", cnt, 0);
    check("m01_one_per_iter", edges, 9 * xs.size());
    check("m01_colour", cols_bad, 0);
    draw(0, 0, 2, 1, 'hFF, 1'b1);
    check("clip_edges", edges, 18);
    check("clip_has_2_0", has(2, 0), 1);
    check("clip_has_0_2", has(0, 2), 1);
`ifdef CIRCLE_CLIP_EN
    check("clip_plots", xs.size(), 6);
    check("clip_no_wrap", has(254, 0), 0);
`else
    check("clip_plots", xs.size(), 16);
    check("clip_wrap_254_0", has(254, 0), 1);
    check("clip_wrap_0_126", has(0, 126), 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
